pokey_pot_scanner: RTL

Parametrised POKEY potentiometer (paddle) scanner replacing the fixed two-pot header wiring in the POKEY top level. It discharges the external pot capacitors, releases them on a POTGO strobe, and times each channel's comparator crossing with a line-rate or fast (per-clock) counter. It produces per-channel POTn values and ALLPOT status for the POKEY register file, and drives the dump/release header outputs.

---
 rtl/pokey_pot_scanner.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pokey_pot_scanner.sv
// pokey_pot_scanner
//
// POKEY potentiometer (paddle) scanner. A POTGO strobe dumps the external pot
// capacitors for DUMP_CYCLES clocks and then releases them. Each channel's
// comparator crossing is timed against a shared counter that advances once per
// line (SLOW_DIV clocks) or once per clock in fast mode. The scan always runs
// to MAX_COUNT, so the capacitors stay released for a fixed scan length.
//
// Ports:
//   clk        system clock, the only clock
//   rst_b      synchronous active-low reset
//   potgo      one-cycle strobe from a POTGO register write
//   fast_scan  fast (per-clock) scan request, sampled only with potgo
//   pot_in     raw asynchronous comparator inputs, 1 = threshold crossed
//   pot_val    channel i value at [i*CNT_W +: CNT_W]
//   allpot     bit i = 1 while channel i is still scanning
//   pot_dump   1 = capacitors shorted, 0 = released
//   scan_busy  1 while dumping or scanning
//
// Build option: define POKEY_POT_FAST_SCAN_EN to honour fast_scan. Without it
// the port is ignored, every scan runs at line rate and no fast path exists.
//
// Handshake: potgo is a single-cycle strobe with no ready; it is accepted in
// every state and always restarts the dump/scan sequence.

module pokey_pot_scanner #(
    parameter int NUM_POTS    = 8,
    parameter int CNT_W       = 8,
    parameter int MAX_COUNT   = 228,
    parameter int SLOW_DIV    = 114,
    parameter int DUMP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      potgo,
    input  logic                      fast_scan,
    input  logic [NUM_POTS-1:0]       pot_in,
    output logic [NUM_POTS*CNT_W-1:0] pot_val,
    output logic [NUM_POTS-1:0]       allpot,
    output logic                      pot_dump,
    output logic                      scan_busy
);

    localparam int PRE_W = (SLOW_DIV > 2) ? $clog2(SLOW_DIV) : 1;
    localparam int DMP_W = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SLOW_DIV - 1);
    localparam logic [DMP_W-1:0] DMP_LAST  = DMP_W'(DUMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t                state;
    logic [NUM_POTS-1:0]   pot_m;
    logic [NUM_POTS-1:0]   pot_s;
    logic [CNT_W-1:0]      count;
    logic [PRE_W-1:0]      prescale;
    logic [DMP_W-1:0]      dump_cnt;
    logic                  tick;
    logic                  last_tick;
    logic [NUM_POTS-1:0]   latch_mask;

    // Two-flop synchroniser; all scan decisions use pot_s.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            pot_m <= '0;
            pot_s <= '0;
        end else begin
            pot_m <= pot_in;
            pot_s <= pot_m;
        end
    end

`ifdef POKEY_POT_FAST_SCAN_EN
    logic fast_mode;

    // Scan mode is frozen at potgo so mid-scan SKCTL writes have no effect.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            fast_mode <= 1'b0;
        end else if (potgo) begin
            fast_mode <= fast_scan;
        end
    end

    assign tick = (state == ST_SCAN) && (fast_mode || (prescale == PRE_LAST));
`else
    logic unused_fast_scan;
    assign unused_fast_scan = fast_scan;
    assign tick = (state == ST_SCAN) && (prescale == PRE_LAST);
`endif

    // On the terminal tick every channel still scanning latches MAX_COUNT,
    // which is the counter value on that tick.
    assign last_tick  = tick && (count == CNT_LAST);
    assign latch_mask = tick ? (allpot & (pot_s | {NUM_POTS{last_tick}})) : '0;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= ST_IDLE;
            pot_dump  <= 1'b1;
            scan_busy <= 1'b0;
            allpot    <= '0;
            count     <= '0;
            prescale  <= '0;
            dump_cnt  <= '0;
            pot_val   <= '0;
        end else if (potgo) begin
            // Restart from any state; pot_val keeps the previous results.
            state     <= ST_DUMP;
            pot_dump  <= 1'b1;
            scan_busy <= 1'b1;
            allpot    <= '1;
            count     <= '0;
            prescale  <= '0;
            dump_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pot_dump  <= 1'b1;
                    scan_busy <= 1'b0;
                end
                ST_DUMP: begin
                    if (dump_cnt == DMP_LAST) begin
                        state    <= ST_SCAN;
                        pot_dump <= 1'b0;
                    end else begin
                        dump_cnt <= dump_cnt + DMP_W'(1);
                    end
                end
                ST_SCAN: begin
                    prescale <= (prescale == PRE_LAST) ? '0 : prescale + PRE_W'(1);
                    if (tick) begin
                        for (int i = 0; i < NUM_POTS; i++) begin
                            if (latch_mask[i]) begin
                                pot_val[i*CNT_W +: CNT_W] <= count;
                            end
                        end
                        allpot <= allpot & ~latch_mask;
                        if (last_tick) begin
                            state     <= ST_IDLE;
                            pot_dump  <= 1'b1;
                            scan_busy <= 1'b0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pot_dump  <= 1'b1;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
